mem_port_arbiter: RTL

Arbitrates the hart's instruction-fetch port and load/store port onto a single shared memory port with one outstanding transaction. Sits between `riscv.Hart` and the unified SRAM/bus adapter. Latches the winning request, drives the memory request handshake, and routes the memory response back to the owning requester. Strict data-over-fetch priority, with an optional starvation guard.

---
 rtl/mem_port_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one memory port between the hart's instruction-fetch
//             and load/store ports, with one transaction outstanding at a
//             time. Data requests have priority over fetch requests.
//  Options  : MEM_ARB_STARVE_GUARD_EN - when defined, fetch is granted once
//             data has won STARVE_LIMIT contested grants in a row.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                i_req_valid,
    output logic                i_req_ready,
    input  logic [ADDR_W-1:0]   i_req_addr,
    output logic                i_rsp_valid,
    output logic [DATA_W-1:0]   i_rsp_data,

    input  logic                d_req_valid,
    output logic                d_req_ready,
    input  logic [ADDR_W-1:0]   d_req_addr,
    input  logic [DATA_W/8-1:0] d_req_wmask,
    input  logic [DATA_W-1:0]   d_req_wdata,
    output logic                d_rsp_valid,
    output logic [DATA_W-1:0]   d_rsp_data,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [DATA_W/8-1:0] mem_req_wmask,
    output logic [DATA_W-1:0]   mem_req_wdata,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_data,

    output logic                busy
);

    localparam int c_strb_w = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    state_t                r_state;
    state_t                w_state_next;
    owner_t                r_owner;
    logic [ADDR_W-1:0]     r_addr;
    logic [c_strb_w-1:0]   r_wmask;
    logic [DATA_W-1:0]     r_wdata;

    logic                  w_fetch_turn;
    logic                  w_grant_data;
    logic                  w_grant_fetch;

    // Data wins in IDLE unless the starvation guard has handed the turn to fetch.
    // Grants are suppressed while reset is held so no request is acknowledged
    // and then silently dropped.
    assign w_grant_data  = (r_state == ST_IDLE) && !rst && d_req_valid
                           && !(i_req_valid && w_fetch_turn);
    assign w_grant_fetch = (r_state == ST_IDLE) && !rst && i_req_valid
                           && !w_grant_data;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int                 c_cnt_w   = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(STARVE_LIMIT);

    logic [c_cnt_w-1:0] r_starve_cnt;

    assign w_fetch_turn = (r_starve_cnt == c_cnt_max);

    // Count contested data grants (saturating); any fetch or uncontested data grant clears.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (w_grant_data) begin
            if (!i_req_valid) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != c_cnt_max) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end else if (w_grant_fetch) begin
            r_starve_cnt <= '0;
        end
    end
`else
    // Strict priority: fetch never gets a forced turn.
    logic w_unused_limit;
    assign w_unused_limit = (STARVE_LIMIT > 0);
    assign w_fetch_turn   = 1'b0;
`endif

    // State and owner registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_owner <= OWN_FETCH;
        end else begin
            r_state <= w_state_next;
            if (w_grant_data) begin
                r_owner <= OWN_DATA;
            end else if (w_grant_fetch) begin
                r_owner <= OWN_FETCH;
            end
        end
    end

    // Request latch: captured on grant and held until the next grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_wmask <= '0;
            r_wdata <= '0;
        end else if (w_grant_data) begin
            r_addr  <= d_req_addr;
            r_wmask <= d_req_wmask;
            r_wdata <= d_req_wdata;
        end else if (w_grant_fetch) begin
            r_addr  <= i_req_addr;
            r_wmask <= '0;
            r_wdata <= '0;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_next  = r_state;
        i_req_ready   = 1'b0;
        d_req_ready   = 1'b0;
        i_rsp_valid   = 1'b0;
        d_rsp_valid   = 1'b0;
        mem_req_valid = 1'b0;

        case (r_state)
            ST_IDLE: begin
                d_req_ready = w_grant_data;
                i_req_ready = w_grant_fetch;
                if (w_grant_data || w_grant_fetch) begin
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_req_valid = !rst;
                if (mem_req_ready) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rsp_valid && !rst) begin
                    i_rsp_valid  = (r_owner == OWN_FETCH);
                    d_rsp_valid  = (r_owner == OWN_DATA);
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Response data is steered to both ports; only the owner's valid qualifies it.
    assign i_rsp_data    = mem_rsp_data;
    assign d_rsp_data    = mem_rsp_data;
    assign mem_req_addr  = r_addr;
    assign mem_req_wmask = r_wmask;
    assign mem_req_wdata = r_wdata;
    assign busy          = (r_state != ST_IDLE);

endmodule
`default_nettype wire
